multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, the maximum number of cycles spent waiting for mem_ready (range 1..255).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port instruction, input, 32 bits: the memory read data, captured into the internal IR when ir_write=1.
REQ-005 SHALL have port mem_ready, input, 1 bit: the memory completes the current access this cycle.
REQ-006 SHALL have port zero, input, 1 bit: the ALU zero flag, valid in EXECUTE.
REQ-007 SHALL have outputs pc_write, ir_write, mem_read, mem_write, reg_write, alu_src, mem_to_reg and pc_src, each 1 bit: datapath strobes and selects.
REQ-008 SHALL have output alu_op, 2 bits: 00=add, 01=pass-B/zero-test, 10=R-type funct.
REQ-009 SHALL have outputs read_register1, read_register2 and write_register, each 5 bits: register file addresses.
REQ-010 SHALL have outputs bus_error and illegal, each 1 bit: sticky fault flags.
REQ-011 SHALL have output state, 3 bits: current FSM state, for debug.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4 and TRAP=7.
REQ-013 FETCH SHALL assert mem_read, and on mem_ready SHALL assert ir_write and pc_write (pc_src=0, PC+4) in that same cycle, then go to DECODE.
REQ-014 DECODE SHALL classify IR[31:21] as R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), LDUR 11111000010, STUR 11111000000, CBZ (IR[31:24]=10110100) or B (IR[31:26]=000101); any other value SHALL raise illegal and go to TRAP.
REQ-015 read_register1 SHALL be IR[9:5]; read_register2 SHALL be IR[4:0] for STUR and CBZ (reg2Loc=1) and IR[20:16] otherwise; write_register SHALL be IR[4:0]; all three SHALL be combinational from IR.
REQ-016 EXECUTE SHALL drive alu_src=1 and alu_op=00 for LDUR/STUR, alu_op=10 for R-type, and alu_op=01 for CBZ.
REQ-017 In EXECUTE, B SHALL assert pc_write with pc_src=1; CBZ SHALL do the same only when zero=1; both SHALL then return to FETCH.
REQ-018 EXECUTE SHALL go to MEMORY for LDUR/STUR and to WRITEBACK for R-type.
REQ-019 MEMORY SHALL hold mem_read (LDUR) or mem_write (STUR) asserted until mem_ready; LDUR SHALL then go to WRITEBACK and STUR to FETCH.
REQ-020 WRITEBACK SHALL assert reg_write for exactly one cycle, with mem_to_reg=1 for LDUR and 0 for R-type, then go to FETCH.
REQ-021 A wait counter SHALL clear on entry to FETCH or MEMORY and count each cycle with mem_ready=0; reaching MEM_WAIT_MAX SHALL set bus_error, deassert all strobes and go to TRAP.
REQ-022 mem_ready arriving in the same cycle the counter reaches MEM_WAIT_MAX SHALL count as success, with no bus_error.
REQ-023 Strobes SHALL be Moore outputs of state plus the decoded class, except the mem_ready- and zero-qualified pc_write/ir_write.
REQ-024 TRAP SHALL be absorbing, with all strobes 0, until reset.
REQ-025 Minimum cycles per instruction SHALL be: B/CBZ 3, R-type 4, STUR 4, LDUR 5, each with single-cycle mem_ready.

Reset
REQ-026 reset SHALL force state=FETCH, IR=0, wait counter=0, bus_error=0 and illegal=0 immediately.
REQ-027 All strobes SHALL be 0 during reset except mem_read, which SHALL follow FETCH.
REQ-028 Reset asserted mid-access SHALL abandon the access with no pc_write or reg_write.

Configuration
REQ-029 Macro MULTICYCLE_CBNZ_EN SHALL, when defined, decode CBNZ (IR[31:24]=10110101) like CBZ, with the branch taken on zero=0.
REQ-030 Without MULTICYCLE_CBNZ_EN, CBNZ SHALL be illegal.

Verification
REQ-031 Reset, then ADD X1,X2,X3 with mem_ready=1 -> states 0,1,2,4,0; reg_write=1 only in cycle 4; write_register=1, read_register2=3.
REQ-032 LDUR with mem_ready delayed 3 cycles in MEMORY -> mem_read held 4 cycles, then WRITEBACK with mem_to_reg=1.
REQ-033 CBZ with zero=1, then with zero=0 -> pc_src=1 and pc_write=1 in EXECUTE; then no pc_write in EXECUTE; read_register2=IR[4:0].
REQ-034 mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 -> bus_error=1 and state=7 after 15 cycles; it stays there until reset.
REQ-035 Opcode 0xB5 in IR[31:24] -> illegal=1 and TRAP without the macro; branch on zero=0 with MULTICYCLE_CBNZ_EN.
REQ-036 Reset pulsed during STUR MEMORY wait -> state=0 asynchronously, mem_write drops, no pc_write, flags clear.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle LEGv8 control FSM: fetch/decode/execute/memory/writeback with bus timeout and illegal trap.
// Define MULTICYCLE_CBNZ_EN to decode CBNZ alongside CBZ.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic [1:0]  alu_op,
  output logic [4:0]  read_register1,
  output logic [4:0]  read_register2,
  output logic [4:0]  write_register,
  output logic        bus_error,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEMORY    = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] TRAP      = 3'd7;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  logic [2:0]  state_q, state_d;
  logic [31:0] ir_q;
  logic [7:0]  wait_q, wait_d;
  logic        bus_err_q, bus_err_d;
  logic        illegal_q, illegal_d;

  logic [10:0] op11;
  logic        is_r, is_ld, is_st, is_cbz, is_cbnz, is_cb, is_b;
  logic        legal, taken, wait_hit;

  assign op11   = ir_q[31:21];
  assign is_r   = (op11 == 11'b10001011000) || (op11 == 11'b11001011000)
               || (op11 == 11'b10001010000) || (op11 == 11'b10101010000);
  assign is_ld  = op11 == 11'b11111000010;
  assign is_st  = op11 == 11'b11111000000;
  assign is_cbz = ir_q[31:24] == 8'hB4;
  assign is_b   = ir_q[31:26] == 6'b000101;

`ifdef MULTICYCLE_CBNZ_EN
  assign is_cbnz = ir_q[31:24] == 8'hB5;
`else
  assign is_cbnz = 1'b0;
`endif

  assign is_cb = is_cbz | is_cbnz;
  assign legal = is_r | is_ld | is_st | is_cb | is_b;
  assign taken = is_b | (is_cbz & zero) | (is_cbnz & ~zero);

  // STUR and CB* read their Rt operand through port 2
  assign read_register1 = ir_q[9:5];
  assign read_register2 = (is_st | is_cb) ? ir_q[4:0] : ir_q[20:16];
  assign write_register = ir_q[4:0];

  logic unused_ir;
  assign unused_ir = ^ir_q[15:10];

  assign wait_hit  = (wait_q + 8'd1) == WAIT_MAX;
  assign state     = state_q;
  assign bus_error = bus_err_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    bus_err_d  = bus_err_q;
    illegal_d  = illegal_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    alu_op     = 2'b00;
    unique case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (wait_hit) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end
      end
      EXECUTE: begin
        alu_src  = is_ld | is_st;
        alu_op   = is_r ? 2'b10 : (is_cb ? 2'b01 : 2'b00);
        pc_src   = is_b | is_cb;
        pc_write = taken;
        if (is_ld | is_st) state_d = MEMORY;
        else if (is_r)     state_d = WRITEBACK;
        else               state_d = FETCH;
      end
      MEMORY: begin
        alu_src   = 1'b1;
        mem_read  = is_ld;
        mem_write = is_st;
        if (mem_ready) begin
          state_d = is_ld ? WRITEBACK : FETCH;
        end else if (wait_hit) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        state_d    = FETCH;
      end
      default: state_d = TRAP;
    endcase
    if ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEMORY)))
      wait_d = 8'd0;
    // reset abandons any in-flight access; only the FETCH read stays visible
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
      if (ir_write) ir_q <= instruction;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller (default MEM_WAIT_MAX=15).
// Honors MULTICYCLE_CBNZ_EN for the CBNZ expectation.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write;
  logic        alu_src, mem_to_reg, pc_src;
  logic [1:0]  alu_op;
  logic [4:0]  read_register1, read_register2, write_register;
  logic        bus_error, illegal;
  logic [2:0]  state;

  int n_pass = 0;
  int n_total = 0;

  multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
    .clock          (clock),
    .reset          (reset),
    .instruction    (instruction),
    .mem_ready      (mem_ready),
    .zero           (zero),
    .pc_write       (pc_write),
    .ir_write       (ir_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .reg_write      (reg_write),
    .alu_src        (alu_src),
    .mem_to_reg     (mem_to_reg),
    .pc_src         (pc_src),
    .alu_op         (alu_op),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .write_register (write_register),
    .bus_error      (bus_error),
    .illegal        (illegal),
    .state          (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic        z;
    int          cycles;
    logic [14:0] regs;
    logic [1:0]  aop;
    logic        asrc;
    logic        pcw;
    int          rwc;
    logic        m2r;
  } vec_t;

  vec_t tbl[9];

  localparam logic [31:0] I_ADD  = {11'b10001011000, 5'd3, 6'd0, 5'd2, 5'd1};
  localparam logic [31:0] I_LDUR = {11'b11111000010, 9'd0, 2'b00, 5'd5, 5'd4};
  localparam logic [31:0] I_STUR = {11'b11111000000, 9'd0, 2'b00, 5'd5, 5'd4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    instruction = '0;
    #1;
    chk("rst state", 32'(state), 32'd0);
    chk("rst mem_read", 32'(mem_read), 32'd1);
    chk("rst strobes", 32'({pc_write, ir_write, reg_write, mem_write}), 32'd0);
    chk("rst flags", 32'({bus_error, illegal}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, rwc;
    logic [14:0] regs;
    logic [1:0] aop;
    logic asrc, pcw, m2r;
    bit done;
    cyc = 0; rwc = 0; regs = '0; aop = '0;
    asrc = 0; pcw = 0; m2r = 0; done = 0;
    instruction = v.instr;
    zero = v.z;
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (i > 0 && state == 3'd0) begin
        done = 1;
      end else begin
        cyc++;
        if (state == 3'd2) begin
          regs = {read_register1, read_register2, write_register};
          aop  = alu_op;
          asrc = alu_src;
          pcw  = pc_write;
        end
        if (reg_write) begin
          rwc++;
          m2r = mem_to_reg;
        end
        @(negedge clock);
      end
    end
    chk($sformatf("vec%0d done", idx), 32'(done), 32'd1);
    chk($sformatf("vec%0d cycles", idx), cyc, v.cycles);
    chk($sformatf("vec%0d regs", idx), 32'(regs), 32'(v.regs));
    chk($sformatf("vec%0d alu_op", idx), 32'(aop), 32'(v.aop));
    chk($sformatf("vec%0d alu_src", idx), 32'(asrc), 32'(v.asrc));
    chk($sformatf("vec%0d exec pc_write", idx), 32'(pcw), 32'(v.pcw));
    chk($sformatf("vec%0d reg_write count", idx), rwc, v.rwc);
    chk($sformatf("vec%0d mem_to_reg", idx), 32'(m2r), 32'(v.m2r));
  endtask

  initial begin
    logic [14:0] trace;
    logic [4:0]  rwp;
    int mcnt, mrd;
    bit got;

    tbl[0] = '{I_ADD, 1'b0, 4, {5'd2, 5'd3, 5'd1}, 2'b10, 1'b0, 1'b0, 1, 1'b0};
    tbl[1] = '{{11'b11001011000, 5'd7, 6'd0, 5'd6, 5'd5}, 1'b0, 4,
               {5'd6, 5'd7, 5'd5}, 2'b10, 1'b0, 1'b0, 1, 1'b0};
    tbl[2] = '{{11'b10001010000, 5'd10, 6'd0, 5'd9, 5'd8}, 1'b0, 4,
               {5'd9, 5'd10, 5'd8}, 2'b10, 1'b0, 1'b0, 1, 1'b0};
    tbl[3] = '{{11'b10101010000, 5'd13, 6'd0, 5'd12, 5'd11}, 1'b0, 4,
               {5'd12, 5'd13, 5'd11}, 2'b10, 1'b0, 1'b0, 1, 1'b0};
    tbl[4] = '{I_LDUR, 1'b0, 5, {5'd5, 5'd0, 5'd4}, 2'b00, 1'b1, 1'b0, 1, 1'b1};
    tbl[5] = '{I_STUR, 1'b0, 4, {5'd5, 5'd4, 5'd4}, 2'b00, 1'b1, 1'b0, 0, 1'b0};
    tbl[6] = '{{8'hB4, 19'd3, 5'd9}, 1'b1, 3, {5'd3, 5'd9, 5'd9}, 2'b01, 1'b0, 1'b1, 0, 1'b0};
    tbl[7] = '{{8'hB4, 19'd3, 5'd9}, 1'b0, 3, {5'd3, 5'd9, 5'd9}, 2'b01, 1'b0, 1'b0, 0, 1'b0};
    tbl[8] = '{{6'b000101, 26'h40}, 1'b0, 3, {5'd2, 5'd0, 5'd0}, 2'b00, 1'b0, 1'b1, 0, 1'b0};

    do_reset();
    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    // ADD state trace 0,1,2,4,0 with reg_write only in cycle 4
    do_reset();
    instruction = I_ADD;
    mem_ready = 1'b1;
    trace = '0;
    rwp = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      trace = {trace[11:0], state};
      rwp = {rwp[3:0], reg_write};
      @(negedge clock);
    end
    chk("add trace", 32'(trace), 32'({3'd0, 3'd1, 3'd2, 3'd4, 3'd0}));
    chk("add reg_write", 32'(rwp), 32'(5'b00010));

    // LDUR with mem_ready late by 3 cycles in MEMORY
    do_reset();
    instruction = I_LDUR;
    mem_ready = 1'b1;
    mcnt = 0; mrd = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (state == 3'd3) begin
        mem_ready = (mcnt == 3);
        mcnt++;
        if (mem_read) mrd++;
      end else begin
        mem_ready = 1'b1;
      end
      if (state == 3'd4) begin
        got = 1;
        chk("ldur wb mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("ldur wb reg_write", 32'(reg_write), 32'd1);
      end else begin
        @(negedge clock);
      end
    end
    chk("ldur reached wb", 32'(got), 32'd1);
    chk("ldur mem_read cycles", mrd, 4);

    // FETCH timeout
    do_reset();
    mem_ready = 1'b0;
    repeat (14) @(negedge clock);
    #1;
    chk("timeout 14 state", 32'(state), 32'd0);
    chk("timeout 14 bus_error", 32'(bus_error), 32'd0);
    @(negedge clock);
    #1;
    chk("timeout 15 state", 32'(state), 32'd7);
    chk("timeout 15 bus_error", 32'(bus_error), 32'd1);
    chk("trap strobes", 32'({mem_read, ir_write, pc_write, mem_write, reg_write}), 32'd0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("trap absorbing", 32'(state), 32'd7);

    // mem_ready on the cycle the counter would hit the limit
    do_reset();
    mem_ready = 1'b0;
    repeat (14) @(negedge clock);
    mem_ready = 1'b1;
    @(negedge clock);
    #1;
    chk("boundary state", 32'(state), 32'd1);
    chk("boundary bus_error", 32'(bus_error), 32'd0);

    // CBNZ
    do_reset();
    instruction = {8'hB5, 19'd0, 5'd2};
    mem_ready = 1'b1;
    zero = 1'b0;
    repeat (2) @(negedge clock);
    #1;
`ifdef MULTICYCLE_CBNZ_EN
    chk("cbnz state", 32'(state), 32'd2);
    chk("cbnz pc_write", 32'(pc_write), 32'd1);
    chk("cbnz illegal", 32'(illegal), 32'd0);
`else
    chk("cbnz state", 32'(state), 32'd7);
    chk("cbnz illegal", 32'(illegal), 32'd1);
    chk("cbnz pc_write", 32'(pc_write), 32'd0);
`endif

    // reset during STUR memory wait
    do_reset();
    instruction = I_STUR;
    mem_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (state == 3'd3) got = 1;
      else @(negedge clock);
    end
    chk("stur reached mem", 32'(got), 32'd1);
    mem_ready = 1'b0;
    @(negedge clock);
    #1;
    chk("stur mem_write held", 32'({state, mem_write}), 32'({3'd3, 1'b1}));
    #1 reset = 1'b1;
    #1;
    chk("midrst state", 32'(state), 32'd0);
    chk("midrst strobes", 32'({mem_write, pc_write, reg_write, ir_write}), 32'd0);
    chk("midrst mem_read", 32'(mem_read), 32'd1);
    chk("midrst flags", 32'({bus_error, illegal}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
